// File: rtl/banked_memory_model.sv
// banked_memory_model: multi-bank cache-line memory with fixed latency and 4-beat burst returns
// Ports: clk/rst (async active-high), addr/read/write/wdata request side with combinational ready,
// raddr/rdata/rvalid response beats, sticky protocol error flag.
module banked_memory_model #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int LATENCY    = 8,
  parameter int LINES      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  error
);
  localparam int LINE_W = BURST_LEN * DATA_WIDTH;
  localparam int OFF = $clog2(LINE_W / 8);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int LW = $clog2(LINES);
  localparam int KW = $clog2(BURST_LEN);
  localparam int CW = $clog2(LATENCY);
  localparam logic [KW-1:0] LAST = KW'(BURST_LEN - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t st [NUM_BANKS];
  logic [CW-1:0] cnt [NUM_BANKS];
  logic wr_bank [NUM_BANKS];
  logic [ADDR_WIDTH-1:0] la [NUM_BANKS];
  logic [LINE_W-1:0] line_q [NUM_BANKS];
  // storage has no reset so its contents survive rst
  logic [LINE_W-1:0] mem [LINES];
  logic wb_active;
  logic [KW-1:0] wb_beat, g_beat;
  logic [BW-1:0] sel, pick, wb_bank, g_bank;
  logic [LW-1:0] wb_line;
  logic [LINE_W-DATA_WIDTH-1:0] wb_buf;
  logic rd_acc, wr_acc, commit, done, err_now, pick_ok;
  logic [DATA_WIDTH-1:0] pick_data;
  assign sel = addr[OFF +: BW];
  assign ready = !rst && (wb_active || st[sel] == IDLE);
  // a cycle with both read and write is a protocol error and starts nothing
  assign rd_acc = read && !write && ready && !wb_active;
  assign wr_acc = write && !read && ready && !wb_active;
  assign commit = wb_active && write && wb_beat == LAST;
  assign done = rvalid && g_beat == LAST;
  assign err_now = (read && write) || ((rd_acc || wr_acc) && addr[OFF-1:0] != '0) || (wb_active && !write);
  // lowest-index bank that is waiting in RESP or finishing its countdown this edge
  always_comb begin
    pick_ok = 1'b0;
    pick = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--)
      if ((st[b] == RESP && !(rvalid && g_bank == BW'(b))) || (st[b] == BUSY && !wr_bank[b] && cnt[b] == '0)) begin
        pick_ok = 1'b1;
        pick = BW'(b);
      end
  end
  // a bank granted on its BUSY->RESP edge takes beat 0 straight from storage
  assign pick_data = st[pick] == RESP ? line_q[pick][DATA_WIDTH-1:0] : mem[la[pick][OFF +: LW]][DATA_WIDTH-1:0];
  always_ff @(posedge clk)
    if (commit) mem[wb_line] <= {wdata, wb_buf};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st[b] <= IDLE;
        cnt[b] <= '0;
        wr_bank[b] <= 1'b0;
        la[b] <= '0;
        line_q[b] <= '0;
      end
      wb_active <= 1'b0;
      wb_beat <= '0;
      wb_bank <= '0;
      wb_line <= '0;
      wb_buf <= '0;
      g_bank <= '0;
      g_beat <= '0;
      rvalid <= 1'b0;
      raddr <= '0;
      rdata <= '0;
      error <= 1'b0;
    end else begin
      error <= error | err_now;
      if (wr_acc) begin
        wb_active <= 1'b1;
        wb_beat <= KW'(1);
        wb_bank <= sel;
        wb_line <= addr[OFF +: LW];
        wb_buf[DATA_WIDTH-1:0] <= wdata;
      end else if (wb_active) begin
        wb_active <= write && wb_beat != LAST;
        wb_beat <= wb_beat + 1'b1;
        if (wb_beat != LAST) wb_buf[wb_beat*DATA_WIDTH +: DATA_WIDTH] <= wdata;
      end
      for (int b = 0; b < NUM_BANKS; b++)
        case (st[b])
          IDLE:
            if ((rd_acc && sel == BW'(b)) || (commit && wb_bank == BW'(b))) begin
              st[b] <= BUSY;
              cnt[b] <= CW'(LATENCY - 1);
              wr_bank[b] <= !rd_acc;
              if (rd_acc) la[b] <= {addr[ADDR_WIDTH-1:OFF], OFF'(0)};
            end
          BUSY:
            if (cnt[b] != '0) cnt[b] <= cnt[b] - 1'b1;
            else begin
              st[b] <= wr_bank[b] ? IDLE : RESP;
              line_q[b] <= mem[la[b][OFF +: LW]];
            end
          RESP:
            if (done && g_bank == BW'(b)) st[b] <= IDLE;
          default: st[b] <= IDLE;
        endcase
      if (rvalid && !done) begin
        g_beat <= g_beat + 1'b1;
        rdata <= line_q[g_bank][(32'(g_beat) + 1) * DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rvalid <= pick_ok;
        g_bank <= pick;
        g_beat <= '0;
        if (pick_ok) begin
          raddr <= la[pick];
          rdata <= pick_data;
        end
      end
    end
endmodule

// File: tb/tb_banked_memory_model.sv
// tb_banked_memory_model: random and directed stimulus checked against a timestamp-based reference model
module tb_banked_memory_model;
  localparam int L = 8;
  logic clk = 0, rst = 1;
  logic [31:0] addr = 0;
  logic read = 0, write = 0;
  logic [63:0] wdata = 0;
  logic ready, rvalid, error;
  logic [31:0] raddr;
  logic [63:0] rdata;
  int total = 0, bad = 0;

  banked_memory_model #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst), .addr(addr), .read(read), .write(write), .wdata(wdata),
    .ready(ready), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: banks hold a kind (0 idle, 1 read, 2 write) and the edge number
  // at which their latency expires; the return port serves one 4-beat burst at a time.
  logic [255:0] mmem [1024];
  int kind [4];
  int bt [4];
  logic [255:0] bdata [4];
  logic [31:0] baddr [4];
  bit p_busy;
  int p_bank, p_start;
  bit in_b;
  int b_beat, b_bank;
  logic [9:0] b_line;
  logic [255:0] b_buf;
  bit m_err;
  int cyc = 0;

  initial for (int i = 0; i < 1024; i++) mmem[i] = '0;

  always @(posedge clk) begin : mdl
    int sb;
    bit rdy, ra, wa;
    cyc++;
    if (rst) begin
      for (int b = 0; b < 4; b++) kind[b] = 0;
      p_busy = 0;
      in_b = 0;
      m_err = 0;
    end else begin
      sb = int'(addr[6:5]);
      rdy = in_b || kind[sb] == 0;
      ra = read && !write && rdy && !in_b;
      wa = write && !read && rdy && !in_b;
      if (read && write) m_err = 1;
      if ((ra || wa) && addr[4:0] != 0) m_err = 1;
      for (int b = 0; b < 4; b++) begin
        if (kind[b] == 1 && bt[b] == cyc) bdata[b] = mmem[baddr[b][14:5]];
        if (kind[b] == 2 && bt[b] == cyc) kind[b] = 0;
      end
      if (p_busy && cyc == p_start + 4) begin
        kind[p_bank] = 0;
        p_busy = 0;
      end
      if (!p_busy)
        for (int b = 3; b >= 0; b--)
          if (kind[b] == 1 && bt[b] <= cyc) begin
            p_busy = 1;
            p_bank = b;
            p_start = cyc;
          end
      if (in_b) begin
        if (write) begin
          b_buf[b_beat*64 +: 64] = wdata;
          if (b_beat == 3) begin
            mmem[b_line] = b_buf;
            kind[b_bank] = 2;
            bt[b_bank] = cyc + L;
            in_b = 0;
          end else b_beat++;
        end else begin
          m_err = 1;
          in_b = 0;
        end
      end
      if (ra) begin
        kind[sb] = 1;
        bt[sb] = cyc + L;
        baddr[sb] = {addr[31:5], 5'b0};
      end
      if (wa) begin
        in_b = 1;
        b_beat = 1;
        b_bank = sb;
        b_line = addr[14:5];
        b_buf[63:0] = wdata;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("rst_ready", ready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_error", error, 0);
    end else begin
      chk("ready", ready, in_b || kind[addr[6:5]] == 0);
      chk("rvalid", rvalid, p_busy);
      if (p_busy) begin
        chk("raddr", raddr, baddr[p_bank]);
        chk("rdata", rdata, bdata[p_bank][(cyc - p_start)*64 +: 64]);
      end
      chk("error", error, m_err);
    end
  end

  logic [63:0] gd [8];
  logic [31:0] ga [8];
  logic gv [8];
  logic [63:0] pat [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};

  task automatic do_write(input logic [31:0] a, input logic [63:0] b0, b1, b2, b3);
    int n = 0;
    do begin
      @(negedge clk); read = 0; write = 1; addr = a; wdata = b0; #1; n++;
    end while (!ready && n < 200);
    chk("wr_accept", ready, 1);
    @(negedge clk); wdata = b1; #1 chk("wr_beat1_ready", ready, 1);
    @(negedge clk); wdata = b2; #1 chk("wr_beat2_ready", ready, 1);
    @(negedge clk); wdata = b3; #1 chk("wr_beat3_ready", ready, 1);
    @(negedge clk); write = 0;
  endtask

  task automatic do_read(input logic [31:0] a);
    int n = 0;
    do begin
      @(negedge clk); read = 1; write = 0; addr = a; #1; n++;
    end while (!ready && n < 200);
    chk("rd_accept", ready, 1);
  endtask

  task automatic grab(input int n, output int lat);
    lat = 0;
    do begin
      @(negedge clk); read = 0; write = 0; #1; lat++;
    end while (!rvalid && lat < 200);
    for (int j = 0; j < n; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      gv[j] = rvalid; gd[j] = rdata; ga[j] = raddr;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; read = 0; write = 0;
    @(negedge clk);
    @(negedge clk); rst = 0;
  endtask

  task automatic count_rvalid(input int n, output int rv);
    rv = 0;
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; if (rvalid) rv++; end
  endtask

  initial begin
    int lat, beats, b3, acc, rv, r, n;
    @(negedge clk); #1;
    chk("reset_ready", ready, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_raddr", raddr, 0);
    chk("reset_error", error, 0);
    @(negedge clk); rst = 0; #1;
    chk("ready_after_reset", ready, 1);

    // write/read of line 0x40; beat 0 starts L edges after the accepting edge
    do_write(32'h40, pat[0], pat[1], pat[2], pat[3]);
    do_read(32'h40);
    grab(4, lat);
    chk("read_latency", lat, L + 1);
    for (int j = 0; j < 4; j++) begin
      chk("line40_valid", gv[j], 1);
      chk("line40_data", gd[j], pat[j]);
      chk("line40_addr", ga[j], 32'h40);
    end

    // consecutive reads to banks 0 and 1 stream back-to-back
    do_write(32'h00, 64'hA0, 64'hA1, 64'hA2, 64'hA3);
    do_write(32'h20, 64'hB0, 64'hB1, 64'hB2, 64'hB3);
    do_write(32'h80, 64'hC0, 64'hC1, 64'hC2, 64'hC3);
    repeat (L + 4) @(negedge clk);
    @(negedge clk); read = 1; addr = 32'h00; #1 chk("b0_ready", ready, 1);
    @(negedge clk); addr = 32'h20; #1 chk("b1_ready", ready, 1);
    grab(8, lat);
    for (int j = 0; j < 8; j++) begin
      chk("b2b_valid", gv[j], 1);
      chk("b2b_data", gd[j], j < 4 ? 64'hA0 + j : 64'hB0 + j - 4);
      chk("b2b_addr", ga[j], j < 4 ? 32'h00 : 32'h20);
    end

    // same-bank reads: second accepted the cycle after the first burst's beat 3
    repeat (4) @(negedge clk);
    @(negedge clk); read = 1; addr = 32'h00;
    @(negedge clk); addr = 32'h80; #1 chk("same_bank_blocked", ready, 0);
    beats = 0; b3 = -1; acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rvalid && raddr == 0) begin beats++; if (beats == 4) b3 = i; end
      if (ready) begin acc = i; break; end
    end
    chk("same_bank_beats", beats, 4);
    chk("same_bank_next", acc, b3 + 1);
    grab(4, lat);
    chk("same_bank_latency", lat, L + 1);
    for (int j = 0; j < 4; j++) begin
      chk("line80_data", gd[j], 64'hC0 + j);
      chk("line80_addr", ga[j], 32'h80);
    end

    // random traffic over lines 4..15, upper address bits randomized
    for (int t = 1; t < 4; t++)
      for (int b = 0; b < 4; b++)
        do_write((t << 7) | (b << 5), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (in_b) begin
        read = 0; write = 1; wdata = {$urandom, $urandom};
      end else begin
        r = $urandom_range(0, 99);
        read = r < 45;
        write = r >= 45 && r < 55;
        addr = ($urandom & 32'hFFFF_8000) | ($urandom_range(1, 3) << 7) | ($urandom_range(0, 3) << 5);
        wdata = {$urandom, $urandom};
      end
    end
    n = 0;
    while (in_b && n < 10) begin @(negedge clk); read = 0; write = 1; wdata = {$urandom, $urandom}; n++; end
    @(negedge clk); read = 0; write = 0;
    repeat (60) @(negedge clk);
    #1 chk("random_no_error", error, 0);

    // read during write beats is ignored, ready stays high, rd&wr flags error
    n = 0;
    do begin @(negedge clk); write = 1; read = 0; addr = 32'hA0; wdata = 1; #1; n++; end while (!ready && n < 200);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); wdata = k + 1; read = 1; addr = 32'h0; #1 chk("burst_ready", ready, 1);
    end
    @(negedge clk); read = 0; write = 0;
    count_rvalid(3 * L, rv);
    chk("no_read_during_burst", rv, 0);
    chk("rd_wr_in_burst_error", error, 1);
    do_reset();

    // write dropped at beat 2
    n = 0;
    do begin @(negedge clk); write = 1; addr = 32'hC0; wdata = 7; #1; n++; end while (!ready && n < 200);
    @(negedge clk); wdata = 8;
    @(negedge clk); write = 0;
    @(negedge clk); #1;
    chk("abort_error", error, 1);
    chk("abort_bank_free", ready, 1);
    do_reset();

    // read and write together, sticky
    @(negedge clk); read = 1; write = 1; addr = 32'h0;
    @(negedge clk); read = 0; write = 0; #1 chk("rdwr_error", error, 1);
    repeat (5) @(negedge clk);
    #1 chk("error_sticky", error, 1);
    do_reset();

    // misaligned read
    do_read(32'h44);
    grab(4, lat);
    chk("misalign_error", error, 1);
    chk("misalign_raddr", ga[0], 32'h40);
    do_reset();

    // reset during beat 1 of a response
    do_read(32'h40);
    grab(1, lat);
    chk("pre_rst_rvalid", gv[0], 1);
    @(negedge clk); rst = 1; #1 chk("rst_async_rvalid", rvalid, 0);
    @(negedge clk);
    @(negedge clk); rst = 0; #1 chk("ready_after_midburst_rst", ready, 1);
    count_rvalid(2 * L + 8, rv);
    chk("no_stale_beats", rv, 0);
    do_read(32'h40);
    grab(4, lat);
    for (int j = 0; j < 4; j++) begin
      chk("retained_valid", gv[j], 1);
      chk("retained_data", gd[j], pat[j]);
      chk("retained_addr", ga[j], 32'h40);
    end
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
